// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a small transmit FIFO.
//
// Ports:
//   i_clk   - single clock; all state updates on the rising edge
//   i_rst   - asynchronous active-high reset
//   i_sel   - peripheral select from the address decoder
//   i_we    - store strobe
//   i_add   - byte address; only bits [3:2] are decoded
//   i_data  - store data
//   o_data  - read data, combinational from i_add and current state
//   o_tx    - serial line (8N1, LSB first, idles high), registered
//   o_irq   - high while the FIFO is empty and the transmitter is idle
//
// Register map (i_add[3:2]):
//   0 TXDATA  write pushes i_data[7:0]; reads 0
//   1 STATUS  {.., overflow, busy, empty, full}; write with bit3=1 clears overflow
//   2,3       reserved, read 0, writes ignored
//
// FIFO_DEPTH must be a power of two and at least 2; CLKS_PER_BIT at least 2.

module uart_tx_mmio #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_add,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_tx,
  output logic             o_irq
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int BCW  = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0]  BIT_LAST   = BCW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] COUNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Register state
  state_t          state_q, state_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, busy;
  logic wr_txdata, wr_status, push, pop, ovf_event, bit_done;
  logic [7:0] head;

  // Only bits [3:2] of the address and [7:0] of the data carry meaning.
  logic unused_bits;
  assign unused_bits = ^{i_add[WIDTH-1:4], i_add[1:0], i_data[WIDTH-1:8]};

  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign head       = mem_q[rd_ptr_q];
  assign bit_done   = (bit_cnt_q == BIT_LAST);

  assign wr_txdata = i_sel & i_we & (i_add[3:2] == 2'd0);
  assign wr_status = i_sel & i_we & (i_add[3:2] == 2'd1);
  // Full is judged on the registered count, so a same-cycle pop never
  // makes room for a write that arrives while full.
  assign push      = wr_txdata & ~fifo_full;
  assign ovf_event = wr_txdata & fifo_full;

  // Transmit FSM: next state, serial output and FIFO pop request.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = head;
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_status && i_data[3]) ovf_d = 1'b0;
    // A dropped write in the same cycle as a clear keeps the flag set.
    if (ovf_event) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data[7:0];
  end

  always_comb begin
    o_data = '0;
    if (i_add[3:2] == 2'd1) o_data[3:0] = {ovf_q, busy, fifo_empty, fifo_full};
  end

  assign o_tx  = tx_q;
  assign o_irq = fifo_empty & ~busy;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A serial monitor checks every frame against the queue of bytes the bench
// expects to be transmitted; directed tests check status, timing and reset.

module tb_uart_tx_mmio;

  localparam int W   = 32;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         we  = 1'b0;
  logic [W-1:0] add = 32'h4;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         tx;
  logic         irq;

  uart_tx_mmio #(.WIDTH(W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_sel (sel),
    .i_we  (we),
    .i_add (add),
    .i_data(wdata),
    .o_data(rdata),
    .o_tx  (tx),
    .o_irq (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // ---------------- serial monitor ----------------
  logic [7:0]  exp_q [$];
  int          start_cyc_q [$];
  int          frames_done = 0;
  bit          in_frame = 0;
  logic [39:0] rx_s, rx_e;
  logic [9:0]  rx_fr;
  logic [7:0]  rx_b;
  bit          rx_abort;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        in_frame = 1;
        start_cyc_q.push_back(cyc);
        rx_s = '0;
        rx_s[0] = tx;
        rx_abort = 0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rst) rx_abort = 1;
          rx_s[i] = tx;
        end
        in_frame = 0;
        if (!rx_abort) begin
          if (exp_q.size() == 0) begin
            chk("rx_spurious_frame", 64'(rx_s), 64'h0);
          end else begin
            rx_b  = exp_q.pop_front();
            rx_fr = {1'b1, rx_b, 1'b0};
            for (int i = 0; i < FRAME; i++) rx_e[i] = rx_fr[i / CPB];
            chk($sformatf("rx_frame_%02h", rx_b), 64'(rx_s), 64'(rx_e));
          end
          frames_done++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wr(input logic [W-1:0] a, input logic [W-1:0] d, input logic s);
    @(posedge clk); #1;
    sel = s; we = 1'b1; add = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; add = 32'h4; wdata = '0;
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("frame_wait", 64'(frames_done >= target), 64'h1);
  endtask

  logic [7:0] wrap_bytes [9] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h81, 8'h7E, 8'h0F, 8'hC3, 8'h99};
  int base;
  int busy_gaps;
  bit started;
  int sz;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 64'(tx), 64'h1);
    chk("rst_irq", 64'(irq), 64'h1);
    chk("rst_status", 64'(rdata), 64'h2);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- single byte 0xA5 ----
    exp_q.push_back(8'hA5);
    base = frames_done;
    wr(32'h0, 32'hA5, 1'b1);
    @(negedge clk);
    chk("lat_tx_still_high", 64'(tx), 64'h1);
    @(negedge clk);
    chk("lat_tx_start", 64'(tx), 64'h0);
    chk("busy_in_frame", 64'(rdata), 64'h6);
    wait_frames(base + 1, FRAME + 20);
    repeat (2) @(negedge clk);
    chk("irq_after_a5", 64'(irq), 64'h1);
    chk("status_after_a5", 64'(rdata), 64'h2);

    // ---- back-to-back 0x01, 0x02 ----
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    base = frames_done;
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; add = 32'h0; wdata = 32'h01;
    @(posedge clk); #1;
    wdata = 32'h02;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; add = 32'h4; wdata = '0;
    busy_gaps = 0;
    started = 0;
    for (int n = 0; n < 2 * FRAME + 20; n++) begin
      @(negedge clk); #1;
      if (frames_done >= base + 2) break;
      if (started && rdata[2] !== 1'b1) busy_gaps++;
      if (in_frame) started = 1;
    end
    chk("b2b_frames", 64'(frames_done - base), 64'h2);
    chk("b2b_busy_gaps", 64'(busy_gaps), 64'h0);
    sz = start_cyc_q.size();
    chk("b2b_start_spacing", 64'(start_cyc_q[sz-1] - start_cyc_q[sz-2]), 64'(FRAME));
    repeat (2) @(negedge clk);

    // ---- overflow: 6 consecutive writes while idle ----
    for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h10 + k));
    base = frames_done;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      sel = 1'b1; we = 1'b1; add = 32'h0; wdata = 32'(32'h10 + k);
    end
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; add = 32'h4; wdata = '0;
    #1;
    // Full and overflow set, not empty; busy is also set since byte 0 is on the line.
    chk("ovf_status_full_ovf", 64'(rdata & 32'hB), 64'h9);
    chk("ovf_status_busy", 64'(rdata[2]), 64'h1);
    wr(32'h4, 32'h8, 1'b1);
    chk("ovf_cleared", 64'(rdata), 64'h5);
    wait_frames(base + 5, 5 * FRAME + 40);
    repeat (2) @(negedge clk);
    chk("status_after_ovf", 64'(rdata), 64'h2);

    // ---- decode ----
    wr(32'h0, 32'h77, 1'b0);
    repeat (6) @(negedge clk);
    chk("dec_nosel_status", 64'(rdata), 64'h2);
    chk("dec_nosel_tx", 64'(tx), 64'h1);
    wr(32'h8, 32'h66, 1'b1);
    repeat (6) @(negedge clk);
    chk("dec_off8_status", 64'(rdata), 64'h2);
    chk("dec_off8_irq", 64'(irq), 64'h1);
    add = 32'h0; #1;
    chk("dec_read_txdata", 64'(rdata), 64'h0);
    add = 32'hC; #1;
    chk("dec_read_resvd", 64'(rdata), 64'h0);
    add = 32'h4; #1;

    // ---- reset mid-frame during DATA bit 3 ----
    exp_q.push_back(8'hF0);
    wr(32'h0, 32'hF0, 1'b1);
    repeat (18) @(posedge clk);
    #3;
    chk("mid_bit3_tx", 64'(tx), 64'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 64'(tx), 64'h1);
    chk("mid_rst_status", 64'(rdata), 64'h2);
    chk("mid_rst_irq", 64'(irq), 64'h1);
    exp_q.delete();
    // A write presented during reset must be ignored.
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; add = 32'h0; wdata = 32'h99;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; add = 32'h4; wdata = '0;
    rst = 1'b0;
    #1;
    chk("post_rst_status", 64'(rdata), 64'h2);
    repeat (FRAME + 10) @(posedge clk);
    exp_q.push_back(8'h5A);
    base = frames_done;
    wr(32'h0, 32'h5A, 1'b1);
    wait_frames(base + 1, FRAME + 20);

    // ---- wrap-around: 9 bytes with idle gaps ----
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(wrap_bytes[k]);
      base = frames_done;
      wr(32'h0, 32'(wrap_bytes[k]), 1'b1);
      wait_frames(base + 1, FRAME + 20);
      repeat (3) @(negedge clk);
    end
    chk("exp_queue_drained", 64'(exp_q.size()), 64'h0);
    chk("final_irq", 64'(irq), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
